bus_uart: RTL and testbench
===========================

Name: bus_uart

Overview:
- Memory-mapped UART that sits directly downstream of the maxicore32 system bus, behind the top-level address decoder.
- It consumes the word address, data, byte strobes and read/write strobes that the CPU bus interface drives.
- It returns read data within the same cycle, because the CPU bus has no wait states.
- It provides buffered TX and RX FIFOs, a programmable bit-period divisor, sticky error flags and a level interrupt.

Parameters:
- FIFO_DEPTH_LOG2, 4, log2 of the depth of each FIFO (default 16 entries).
- DEFAULT_DIVISOR, 434, reset value of the BAUD register, in clocks per bit.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- select  input  1  chip select from the address decoder.
- address  input  2  word offset, bus address[3:2].
- data_in  input  32  write data from the CPU.
- data_out  output  32  read data to the CPU; 0 when the block is not selected for a read.
- data_strobes  input  4  byte-lane enables; [0] = bits 7:0.
- read  input  1  read strobe, one clock per access.
- write  input  1  write strobe, one clock per access.
- tx  output  1  serial out, idle high.
- rx  input  1  serial in, asynchronous to clock.
- irq  output  1  level interrupt, active high.

Behaviour:
Reset:
- tx=1, irq=0, data_out=0.
- Both FIFOs empty; BAUD=DEFAULT_DIVISOR; CONTROL=0; all sticky flags 0.
- TX and RX state machines go to IDLE.
- Reset is honoured mid-frame: any in-flight TX/RX byte is abandoned and tx returns to 1 immediately.

Register map (offset: name):
- 0x0 DATA
  - Write with strobe[0]: push data_in[7:0] to the TX FIFO.
  - Read: data_out = {24'h0, RX head}; pop at the closing clock edge if RX is non-empty.
  - Read when RX is empty returns 0 and does not pop.
- 0x4 STATUS (read)
  - bit0 rx_nonempty, bit1 tx_full, bit2 tx_empty_and_idle, bit3 rx_overrun, bit4 frame_err, bit5 tx_drop.
  - bits 15:8 = RX count; bits 23:16 = TX count.
  - Write: each 1 in data_in[5:3] clears the matching sticky flag (strobe[0] required).
- 0x8 BAUD
  - Bits 15:0 = clocks per bit; byte lanes 0 and 1 write independently.
  - Writes below 4 are clamped to 4.
  - Takes effect at the next start bit; frames already in progress keep the old value.
- 0xC CONTROL
  - bit0 rx_irq_en, bit1 tx_irq_en, bit2 err_irq_en.

Bus rules:
- Access happens only when select=1. read and write are never asserted together; if both are, write wins and no pop occurs.
- data_out is combinational from address and state (zero-latency read).
- Lanes with strobe=0 are ignored on write.
- Bits not listed in the register map read as 0.

TX FIFO:
- Push when not full.
- Push when full is dropped and sets tx_drop.
- A push and the TX engine pop in the same clock are both honoured; the count is unchanged.

TX state machine (IDLE -> START -> DATA -> STOP -> IDLE):
- Each state lasts BAUD clocks.
- DATA shifts 8 bits, LSB first.
- Leaving STOP with the FIFO non-empty goes straight to START, giving back-to-back frames with no idle bit.
- In IDLE, a non-empty FIFO pops the head and enters START on the next clock.

RX path:
- rx passes through a 2-flop synchroniser.
- RX state machine (IDLE -> START -> DATA -> STOP -> IDLE):
  - IDLE -> START on a falling edge of the synchronised rx.
  - START samples at BAUD/2 (integer, floor). If the sample is 1, the start is false: return to IDLE with no flag.
  - DATA samples 8 bits, each BAUD clocks after the previous sample.
  - STOP samples once. A 0 discards the byte, sets frame_err, then waits for rx=1 before returning to IDLE.
- A good byte is pushed into RX. If RX is full, the byte is discarded and rx_overrun is set; the FIFO contents are unchanged.
- An RX push and a CPU pop in the same clock are both honoured.

Counts and interrupt:
- Counts are FIFO_DEPTH_LOG2+1 bits, zero-extended to 8 bits.
- Pointers wrap modulo the depth.
- irq = (rx_irq_en & rx_nonempty) | (tx_irq_en & tx FIFO empty) | (err_irq_en & (rx_overrun|frame_err|tx_drop)).
- irq is registered, so it lags state by one clock.

Test Plan:
1. Reset, then read 0x4 -> 0x00000004; read 0x8 -> 434; tx=1; irq=0.
2. BAUD=8; write 0x55 to DATA -> tx low for 8 clocks (start), then 0x55 LSB-first at 8 clocks per bit, then high 8 clocks. STATUS bit2 returns to 1 after the stop bit.
3. BAUD=8; write 17 bytes while the TX engine is busy -> 16 queued and 1 dropped (tx_drop=1, TX count 15 or 16 per engine pop); all 16 bytes transmitted back-to-back. Writing 0x20 to 0x4 clears tx_drop.
4. BAUD=8; loop tx to rx and send 0xA3 -> after the frame, STATUS bit0=1 and RX count=1. Read DATA -> 0xA3, then RX count=0; a second read returns 0.
5. Drive rx with 0x3C but stop bit 0 -> frame_err=1, RX count unchanged. With CONTROL=0x4, irq=1 one clock after the flag sets.
6. Fill RX with 16 bytes, then receive a 17th -> rx_overrun=1 and the first 16 bytes are read back in order. Assert reset mid-RX-frame -> all state returns to reset values and the next clean frame is received correctly.

Source files
------------

// File: rtl/bus_uart.sv
// bus_uart: memory-mapped UART for the maxicore32 system bus.
// Zero-wait-state register interface, 2^FIFO_DEPTH_LOG2-entry TX and RX
// FIFOs, programmable clocks-per-bit divisor, sticky error flags and a
// registered level interrupt.
//
// Bus handshake: an access is one clock wide. It happens when select is
// high together with read or write. Write wins if both are high. A DATA
// read pops the RX FIFO at the closing clock edge of the access, and
// data_out is valid combinationally during that cycle.
module bus_uart #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int DEFAULT_DIVISOR = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        select,
  input  logic [1:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic [3:0]  data_strobes,
  input  logic        read,
  input  logic        write,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int PW    = FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  // Register state
  logic [15:0] baud;
  logic [2:0]  control;
  logic        rx_overrun, frame_err, tx_drop;

  // FIFO storage and bookkeeping
  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0] tx_count, rx_count;

  // TX engine
  tx_state_t   tx_state;
  logic [15:0] tx_cnt, tx_period;
  logic [2:0]  tx_bits;
  logic [7:0]  tx_shift;

  // RX engine
  rx_state_t   rx_state;
  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] rx_cnt, rx_period;
  logic [2:0]  rx_bits;
  logic [7:0]  rx_shift;
  logic        rx_valid, rx_ferr;
  logic [7:0]  rx_byte;

  // Decoded bus events
  logic wr_en, rd_en, wr_data, wr_status, wr_baud, wr_ctrl;
  logic tx_full, tx_push, tx_pop, tx_cnt_end;
  logic rx_full, rx_push, rx_pop, rx_drop;
  logic [15:0] baud_new;
  logic [31:0] status_word;
  logic unused_bits;

  assign unused_bits = ^{data_in[31:16], data_strobes[3:2]};

  assign wr_en     = select & write;
  assign rd_en     = select & read & ~write;
  assign wr_data   = wr_en & (address == 2'd0) & data_strobes[0];
  assign wr_status = wr_en & (address == 2'd1) & data_strobes[0];
  assign wr_baud   = wr_en & (address == 2'd2) & (|data_strobes[1:0]);
  assign wr_ctrl   = wr_en & (address == 2'd3) & data_strobes[0];

  assign tx_full    = (tx_count == CW'(DEPTH));
  assign tx_push    = wr_data & ~tx_full;
  assign tx_cnt_end = (tx_cnt == tx_period - 16'd1);
  // The engine takes the head when idle, or when a stop bit ends and more is queued.
  assign tx_pop     = (tx_count != '0) &&
                      ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_cnt_end));

  assign rx_full = (rx_count == CW'(DEPTH));
  assign rx_push = rx_valid & ~rx_full;
  assign rx_drop = rx_valid & rx_full;
  assign rx_pop  = rd_en & (address == 2'd0) & (rx_count != '0);

  assign baud_new = {data_strobes[1] ? data_in[15:8] : baud[15:8],
                     data_strobes[0] ? data_in[7:0]  : baud[7:0]};

  assign status_word = {8'h00, 8'(tx_count), 8'(rx_count), 2'b00,
                        tx_drop, frame_err, rx_overrun,
                        (tx_count == '0) && (tx_state == TX_IDLE),
                        tx_full, (rx_count != '0)};

  // Zero-latency read mux; zero whenever this block is not being read.
  always_comb begin
    data_out = 32'h0;
    if (select && read) begin
      case (address)
        2'd0:    data_out = {24'h0, (rx_count != '0) ? rx_mem[rx_rp] : 8'h00};
        2'd1:    data_out = status_word;
        2'd2:    data_out = {16'h0, baud};
        default: data_out = {29'h0, control};
      endcase
    end
  end

  // Configuration registers and sticky flags; a new event beats a same-cycle clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      baud       <= 16'(DEFAULT_DIVISOR);
      control    <= 3'b000;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      tx_drop    <= 1'b0;
    end else begin
      if (wr_baud) baud <= (baud_new < 16'd4) ? 16'd4 : baud_new;
      if (wr_ctrl) control <= data_in[2:0];
      if (wr_status && data_in[3]) rx_overrun <= 1'b0;
      if (wr_status && data_in[4]) frame_err  <= 1'b0;
      if (wr_status && data_in[5]) tx_drop    <= 1'b0;
      if (rx_drop)            rx_overrun <= 1'b1;
      if (rx_ferr)            frame_err  <= 1'b1;
      if (wr_data && tx_full) tx_drop    <= 1'b1;
    end
  end

  // FIFO storage writes; contents need no reset because counts gate every read.
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wp] <= data_in[7:0];
    if (rx_push) rx_mem[rx_wp] <= rx_byte;
  end

  // FIFO pointers and occupancy counts; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_count <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  // TX state machine: the divisor is latched at each start bit so a frame keeps its rate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state  <= TX_IDLE;
      tx        <= 1'b1;
      tx_cnt    <= 16'd0;
      tx_period <= 16'(DEFAULT_DIVISOR);
      tx_bits   <= 3'd0;
      tx_shift  <= 8'h00;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx <= 1'b1;
          if (tx_count != '0) begin
            tx_state  <= TX_START;
            tx        <= 1'b0;
            tx_shift  <= tx_mem[tx_rp];
            tx_period <= baud;
            tx_cnt    <= 16'd0;
          end
        end
        TX_START: begin
          if (tx_cnt_end) begin
            tx_cnt   <= 16'd0;
            tx_state <= TX_DATA;
            tx       <= tx_shift[0];
            tx_bits  <= 3'd0;
          end else tx_cnt <= tx_cnt + 16'd1;
        end
        TX_DATA: begin
          if (tx_cnt_end) begin
            tx_cnt <= 16'd0;
            if (tx_bits == 3'd7) begin
              tx_state <= TX_STOP;
              tx       <= 1'b1;
            end else begin
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx       <= tx_shift[1];
              tx_bits  <= tx_bits + 3'd1;
            end
          end else tx_cnt <= tx_cnt + 16'd1;
        end
        default: begin
          if (tx_cnt_end) begin
            tx_cnt <= 16'd0;
            if (tx_count != '0) begin
              tx_state  <= TX_START;
              tx        <= 1'b0;
              tx_shift  <= tx_mem[tx_rp];
              tx_period <= baud;
            end else tx_state <= TX_IDLE;
          end else tx_cnt <= tx_cnt + 16'd1;
        end
      endcase
    end
  end

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX state machine: mid-bit sampling, one-clock valid/frame-error pulses toward the FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= 16'd0;
      rx_period <= 16'(DEFAULT_DIVISOR);
      rx_bits   <= 3'd0;
      rx_shift  <= 8'h00;
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
      rx_byte   <= 8'h00;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state  <= RX_START;
            rx_cnt    <= 16'd1;
            rx_period <= baud;
          end
        end
        RX_START: begin
          if (rx_cnt == {1'b0, rx_period[15:1]}) begin
            rx_cnt  <= 16'd0;
            rx_bits <= 3'd0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        RX_DATA: begin
          if (rx_cnt == rx_period - 16'd1) begin
            rx_cnt   <= 16'd0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bits == 3'd7) rx_state <= RX_STOP;
            else rx_bits <= rx_bits + 3'd1;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        RX_STOP: begin
          if (rx_cnt == rx_period - 16'd1) begin
            rx_cnt <= 16'd0;
            if (rx_s2) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_shift;
              rx_state <= RX_IDLE;
            end else begin
              rx_ferr  <= 1'b1;
              rx_state <= RX_BREAK;
            end
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        default: begin
          if (rx_s2) rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  // Registered level interrupt, one clock behind the state it reflects.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) irq <= 1'b0;
    else irq <= (control[0] & (rx_count != '0)) |
                (control[1] & (tx_count == '0)) |
                (control[2] & (rx_overrun | frame_err | tx_drop));
  end

endmodule

// File: tb/tb_bus_uart.sv
// Bench for bus_uart: random bytes through TX, loopback and a driven RX line,
// checked against a serial-frame model and expected-byte queues.
module tb_bus_uart;

  logic        clock = 1'b0;
  logic        reset;
  logic        select;
  logic [1:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [3:0]  data_strobes;
  logic        read;
  logic        write;
  logic        tx;
  logic        rx_drv;
  logic        loop_en;
  logic        rx_line;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       stop_q[$];
  int         start_q[$];

  assign rx_line = loop_en ? tx : rx_drv;

  bus_uart #(.FIFO_DEPTH_LOG2(4), .DEFAULT_DIVISOR(434)) dut (
    .clock(clock), .reset(reset), .select(select), .address(address),
    .data_in(data_in), .data_out(data_out), .data_strobes(data_strobes),
    .read(read), .write(write), .tx(tx), .rx(rx_line), .irq(irq)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Watchdog
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clock);
    select = 1'b1; write = 1'b1; address = a; data_in = d; data_strobes = s;
    @(negedge clock);
    select = 1'b0; write = 1'b0; data_in = 32'h0; data_strobes = 4'h0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clock);
    select = 1'b1; read = 1'b1; address = a;
    #1 d = data_out;
    @(negedge clock);
    select = 1'b0; read = 1'b0;
  endtask

  // Drive one frame on rx: start, 8 data bits LSB first, stop, then one idle bit.
  task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit, input int baud);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); rx_drv = bits[i];
      repeat (baud - 1) @(negedge clock);
    end
    @(negedge clock); rx_drv = 1'b1;
    repeat (baud - 1) @(negedge clock);
  endtask

  // Decode one frame from tx by sampling at mid-bit.
  task automatic capture_frame(input int baud, output logic [7:0] b, output logic stop_v,
                               output int t0, output bit timed_out);
    int n;
    b = 8'h00; stop_v = 1'b0; t0 = 0; timed_out = 1'b0; n = 0;
    @(negedge clock);
    while (tx !== 1'b0 && n < 3000) begin @(negedge clock); n++; end
    if (tx !== 1'b0) begin timed_out = 1'b1; return; end
    t0 = cyc;
    repeat (baud / 2) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      repeat (baud) @(negedge clock);
      b[i] = tx;
    end
    repeat (baud) @(negedge clock);
    stop_v = tx;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    vectors++;
    if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b expected 1", tx); end
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", irq); end
    bus_read(2'd1, d);
    vectors++;
    if (d !== 32'h0000_0004) begin miscompares++; $display("FAIL reset_status: got %h expected 00000004", d); end
    bus_read(2'd2, d);
    vectors++;
    if (d !== 32'd434) begin miscompares++; $display("FAIL reset_baud: got %0d expected 434", d); end
    bus_read(2'd3, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_control: got %h expected 0", d); end
    bus_read(2'd0, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_data_empty: got %h expected 0", d); end
    vectors++;
    if (data_out !== 32'h0) begin miscompares++; $display("FAIL unselected_data_out: got %h expected 0", data_out); end
  endtask

  task automatic test_baud();
    logic [31:0] d;
    bus_write(2'd2, 32'h0000_0002, 4'b0011);
    bus_read(2'd2, d);
    vectors++;
    if (d !== 32'd4) begin miscompares++; $display("FAIL baud_clamp: got %0d expected 4", d); end
    bus_write(2'd2, 32'h0000_0008, 4'b0011);
    bus_write(2'd2, 32'hFFFF_1234, 4'b0010);
    bus_read(2'd2, d);
    vectors++;
    if (d !== 32'h0000_1208) begin miscompares++; $display("FAIL baud_lane1: got %h expected 00001208", d); end
    bus_write(2'd2, 32'h0000_0008, 4'b0011);
    bus_read(2'd2, d);
    vectors++;
    if (d !== 32'd8) begin miscompares++; $display("FAIL baud_set: got %0d expected 8", d); end
  endtask

  // Compare the tx waveform of a single frame clock-by-clock against the frame rules.
  task automatic test_tx_frame(input logic [7:0] b);
    logic [31:0] d;
    logic exp_bit;
    int slot;
    int bad;
    bad = 0;
    bus_write(2'd0, {24'h0, b}, 4'b0001);
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      slot = i / 8;
      exp_bit = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : b[slot - 1];
      vectors++;
      if (tx !== exp_bit) begin
        miscompares++; bad++;
        if (bad < 5) $display("FAIL tx_wave byte %h clk %0d: got %b expected %b", b, i, tx, exp_bit);
      end
    end
    bus_read(2'd1, d);
    vectors++;
    if (d[2] !== 1'b1) begin miscompares++; $display("FAIL tx_idle_after_stop: got %b expected 1", d[2]); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    logic [7:0]  b, gb;
    logic        sv;
    int          t0;
    bit          to;
    exp_q.delete(); got_q.delete(); stop_q.delete(); start_q.delete();
    fork
      begin
        for (int k = 0; k < 17; k++) begin
          capture_frame(8, gb, sv, t0, to);
          if (to) break;
          got_q.push_back(gb); stop_q.push_back(sv); start_q.push_back(t0);
        end
      end
      begin
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        bus_write(2'd0, {24'h0, b}, 4'b0001);
        repeat (3) @(negedge clock);
        for (int k = 0; k < 17; k++) begin
          b = 8'($urandom_range(0, 255));
          if (k < 16) exp_q.push_back(b);
          bus_write(2'd0, {24'h0, b}, 4'b0001);
        end
        bus_read(2'd1, d);
        vectors++;
        if (d !== 32'h0010_0022) begin miscompares++; $display("FAIL tx_full_status: got %h expected 00100022", d); end
      end
    join
    vectors++;
    if (got_q.size() != 17) begin miscompares++; $display("FAIL tx_frame_count: got %0d expected 17", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k] || stop_q[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL tx_fifo_byte %0d: got %h stop %b expected %h stop 1", k, got_q[k], stop_q[k], exp_q[k]);
      end
      if (k > 0) begin
        vectors++;
        if (start_q[k] - start_q[k-1] != 80) begin
          miscompares++;
          $display("FAIL tx_back_to_back %0d: got spacing %0d expected 80", k, start_q[k] - start_q[k-1]);
        end
      end
    end
    repeat (16) @(negedge clock);
    bus_write(2'd1, 32'h0000_0020, 4'b0001);
    bus_read(2'd1, d);
    vectors++;
    if (d !== 32'h0000_0004) begin miscompares++; $display("FAIL tx_drop_clear: got %h expected 00000004", d); end
  endtask

  task automatic test_loopback(input logic [7:0] b);
    logic [31:0] d;
    int n;
    loop_en = 1'b1;
    bus_write(2'd0, {24'h0, b}, 4'b0001);
    n = 0;
    d = 32'h0;
    while (d[0] !== 1'b1 && n < 300) begin bus_read(2'd1, d); n++; end
    vectors++;
    if ((d & 32'h0000_FF01) !== 32'h0000_0101) begin
      miscompares++; $display("FAIL loop_rx_status: got %h expected rx count 1 and nonempty", d);
    end
    bus_read(2'd0, d);
    vectors++;
    if (d !== {24'h0, b}) begin miscompares++; $display("FAIL loop_rx_data: got %h expected %h", d, b); end
    bus_read(2'd1, d);
    vectors++;
    if ((d & 32'h0000_FF01) !== 32'h0) begin miscompares++; $display("FAIL loop_rx_popped: got %h expected count 0", d); end
    bus_read(2'd0, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL loop_empty_read: got %h expected 0", d); end
    repeat (20) @(negedge clock);
    loop_en = 1'b0;
  endtask

  task automatic test_frame_err();
    logic [31:0] d;
    bus_write(2'd3, 32'h0000_0004, 4'b0001);
    @(negedge clock);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL ferr_irq_before: got %b expected 0", irq); end
    drive_rx_frame(8'h3C, 1'b0, 8);
    bus_read(2'd1, d);
    vectors++;
    if ((d & 32'h0000_FF11) !== 32'h0000_0010) begin
      miscompares++; $display("FAIL ferr_status: got %h expected frame_err set, rx count 0", d);
    end
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL ferr_irq: got %b expected 1", irq); end
    bus_write(2'd1, 32'h0000_0010, 4'b0001);
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_lag: got %b expected 1", irq); end
    @(negedge clock);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_cleared: got %b expected 0", irq); end
    bus_write(2'd3, 32'h0000_0000, 4'b0001);
  endtask

  task automatic test_rx_overrun_and_reset();
    logic [31:0] d;
    logic [7:0]  b, e;
    exp_q.delete();
    for (int k = 0; k < 17; k++) begin
      b = 8'($urandom_range(0, 255));
      if (k < 16) exp_q.push_back(b);
      drive_rx_frame(b, 1'b1, 8);
    end
    bus_read(2'd1, d);
    vectors++;
    if ((d & 32'h0000_FF09) !== 32'h0000_1009) begin
      miscompares++; $display("FAIL rx_overrun_status: got %h expected count 16, overrun, nonempty", d);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus_read(2'd0, d);
      vectors++;
      if (d !== {24'h0, e}) begin miscompares++; $display("FAIL rx_fifo_order: got %h expected %h", d, e); end
    end
    bus_read(2'd1, d);
    vectors++;
    if ((d & 32'h0000_FF01) !== 32'h0) begin miscompares++; $display("FAIL rx_drained: got %h expected count 0", d); end

    // Reset while both a TX frame of zeros and an RX frame are in flight.
    bus_write(2'd0, 32'h0000_0000, 4'b0001);
    fork
      drive_rx_frame(8'($urandom_range(0, 255)), 1'b1, 8);
      begin
        repeat (30) @(negedge clock);
        vectors++;
        if (tx !== 1'b0) begin miscompares++; $display("FAIL tx_midframe: got %b expected 0", tx); end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_async_tx: got %b expected 1", tx); end
      end
    join
    repeat (3) @(negedge clock);
    reset = 1'b0;
    test_reset();
    bus_write(2'd2, 32'h0000_0008, 4'b0011);
    b = 8'($urandom_range(0, 255));
    drive_rx_frame(b, 1'b1, 8);
    bus_read(2'd1, d);
    vectors++;
    if ((d & 32'h0000_FF19) !== 32'h0000_0101) begin
      miscompares++; $display("FAIL post_reset_rx_status: got %h expected count 1, no errors", d);
    end
    bus_read(2'd0, d);
    vectors++;
    if (d !== {24'h0, b}) begin miscompares++; $display("FAIL post_reset_rx_data: got %h expected %h", d, b); end
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset = 1'b1; select = 1'b0; address = 2'd0; data_in = 32'h0;
    data_strobes = 4'h0; read = 1'b0; write = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_baud();
    test_tx_frame(8'h55);
    test_tx_frame(8'($urandom_range(0, 255)));
    test_tx_overflow();
    test_loopback(8'hA3);
    test_loopback(8'($urandom_range(0, 255)));
    test_frame_err();
    test_rx_overrun_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
